// File: rtl/prio_rr_sched.sv
// prio_rr_sched: one-hot grant of a shared select/compare datapath by priority, round-robin ties,
// and forced revoke after MAX_HOLD cycles. Define PRIO_RR_SCHED_AGING_EN to enable age counters.
module prio_rr_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned PW       = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IDW      = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*PW-1:0] i_prio,
  output logic [NREQ-1:0]    o_grant,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
`ifdef PRIO_RR_SCHED_AGING_EN
  localparam int unsigned KW = PW + 1;
`else
  localparam int unsigned KW = PW;
`endif

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StArb, StGrant, StGap} state_e;

  state_e             r_state, w_state_nxt;
  logic [NREQ-1:0]    r_snap_req, w_snap_req_nxt;
  logic [NREQ*PW-1:0] r_snap_prio, w_snap_prio_nxt;
  logic [IDW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [HCW-1:0]     r_hold_cnt, w_hold_cnt_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [IDW-1:0]     r_grant_id, w_grant_id_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic [KW-1:0]      w_key [NREQ];
  logic [KW-1:0]      w_max_key;
  logic [IDW-1:0]     w_win_id;
  logic               w_win_live;
  logic               w_owner_req;
  logic               w_hold_max;
  logic               w_req_any;

`ifdef PRIO_RR_SCHED_AGING_EN
  logic [1:0]         r_age [NREQ];
  logic [1:0]         w_age_nxt [NREQ];
`endif

  assign w_req_any   = |i_req;
  assign w_win_live  = i_req[w_win_id];
  assign w_owner_req = i_req[r_grant_id];
  assign w_hold_max  = (r_hold_cnt == HCW'(MAX_HOLD));

  // Arbitration key: a fully aged requester sits above every plain priority code.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef PRIO_RR_SCHED_AGING_EN
      w_key[i] = {r_age[i] == 2'd3, r_snap_prio[i*PW +: PW]};
`else
      w_key[i] = r_snap_prio[i*PW +: PW];
`endif
    end
  end

  always_comb begin
    w_max_key = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_snap_req[i] && (w_key[i] > w_max_key)) begin
        w_max_key = w_key[i];
      end
    end
  end

  // First requester holding the max key, scanning upward from the round-robin pointer.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    logic           found;
    idx      = 0;
    idx_w    = '0;
    found    = 1'b0;
    w_win_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_w = IDW'(idx);
      if (!found && r_snap_req[idx_w] && (w_key[idx_w] == w_max_key)) begin
        found    = 1'b1;
        w_win_id = idx_w;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_req_any) w_state_nxt = StArb;
      StArb:   w_state_nxt = w_win_live ? StGrant : StIdle;
      StGrant: if (!w_owner_req || w_hold_max) w_state_nxt = StGap;
      StGap:   w_state_nxt = w_req_any ? StArb : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_snap_req_nxt  = r_snap_req;
    w_snap_prio_nxt = r_snap_prio;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_grant_nxt     = r_grant;
    w_grant_id_nxt  = r_grant_id;
    w_busy_nxt      = r_busy;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      StIdle, StGap: begin
        if (w_req_any) begin
          w_snap_req_nxt  = i_req;
          w_snap_prio_nxt = i_prio;
        end
      end
      StArb: begin
        // A winner that already withdrew gets nothing; the snapshot is simply dropped.
        if (w_win_live) begin
          w_grant_nxt    = NREQ'(1) << w_win_id;
          w_grant_id_nxt = w_win_id;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = HCW'(1);
          w_rr_ptr_nxt   = (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;
        end
      end
      StGrant: begin
        if (!w_owner_req) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else if (w_hold_max) begin
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef PRIO_RR_SCHED_AGING_EN
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_age_nxt[i] = r_age[i];
      if (r_state == StArb) begin
        if (!r_snap_req[i] || (IDW'(i) == w_win_id)) begin
          w_age_nxt[i] = 2'd0;
        end else if (r_age[i] != 2'd3) begin
          w_age_nxt[i] = r_age[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_age[i] <= 2'd0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_age[i] <= w_age_nxt[i];
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap_req  <= '0;
      r_snap_prio <= '0;
      r_rr_ptr    <= '0;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_snap_req  <= w_snap_req_nxt;
      r_snap_prio <= w_snap_prio_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_busy      <= w_busy_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_prio_rr_sched.sv
// Bench for prio_rr_sched: directed scenarios plus randomized traffic compared each cycle
// against a scoring-based reference model.
module tb_prio_rr_sched;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned PW       = 3;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned IDW      = 2;
  localparam int          N        = NREQ;
`ifdef PRIO_RR_SCHED_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  localparam int PhIdle = 0;
  localparam int PhArb  = 1;
  localparam int PhHold = 2;
  localparam int PhGap  = 3;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req   = '0;
  logic [NREQ*PW-1:0] prio  = '0;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               timeout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int e;

  always #5 clk = ~clk;

  prio_rr_sched #(
    .NREQ    (NREQ),
    .PW      (PW),
    .MAX_HOLD(MAX_HOLD),
    .IDW     (IDW)
  ) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_prio    (prio),
    .o_grant   (grant),
    .o_grant_id(grant_id),
    .o_busy    (busy),
    .o_timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_prio(input int i, input int v);
    prio[i*PW +: PW] = PW'(v);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Reference: every snapshotted requester gets a score; the highest score wins.
  // Score = effective priority, then closeness to the round-robin pointer.
  function automatic int pick(input logic [NREQ-1:0] sr, input logic [NREQ*PW-1:0] sp,
                              input int rr, input logic [NREQ-1:0][1:0] ag);
    int best, best_score, key, score;
    best       = 0;
    best_score = -1;
    for (int i = 0; i < N; i++) begin
      if (sr[i]) begin
        key = int'(sp[i*PW +: PW]);
        if (AGING && ag[i] == 2'd3) key = key + (1 << PW);
        score = key * N + (N - 1 - ((i - rr + N) % N));
        if (score > best_score) begin
          best_score = score;
          best       = i;
        end
      end
    end
    return best;
  endfunction

  logic [NREQ-1:0]       m_snap_req;
  logic [NREQ*PW-1:0]    m_snap_prio;
  logic [NREQ-1:0][1:0]  m_age;
  logic [NREQ-1:0]       m_grant;
  logic                  m_busy, m_timeout;
  int                    m_phase, m_rr, m_held, m_id, m_win;

  always_comb m_win = pick(m_snap_req, m_snap_prio, m_rr, m_age);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PhIdle; m_rr <= 0; m_held <= 0; m_id <= 0;
      m_grant <= '0; m_busy <= 1'b0; m_timeout <= 1'b0;
      m_snap_req <= '0; m_snap_prio <= '0; m_age <= '0;
    end else begin
      m_timeout <= 1'b0;
      case (m_phase)
        PhIdle, PhGap: begin
          if (req != '0) begin
            m_snap_req  <= req;
            m_snap_prio <= prio;
            m_phase     <= PhArb;
          end else begin
            m_phase <= PhIdle;
          end
        end
        PhArb: begin
          if (AGING) begin
            for (int i = 0; i < N; i++) begin
              if (!m_snap_req[i] || i == m_win) m_age[i] <= 2'd0;
              else if (m_age[i] != 2'd3) m_age[i] <= m_age[i] + 2'd1;
            end
          end
          if (req[m_win]) begin
            m_grant <= NREQ'(1) << m_win;
            m_id    <= m_win;
            m_busy  <= 1'b1;
            m_held  <= 1;
            m_rr    <= (m_win + 1) % N;
            m_phase <= PhHold;
          end else begin
            m_phase <= PhIdle;
          end
        end
        PhHold: begin
          if (!req[m_id]) begin
            m_grant <= '0; m_busy <= 1'b0; m_phase <= PhGap;
          end else if (m_held == MAX_HOLD) begin
            m_grant <= '0; m_busy <= 1'b0; m_timeout <= 1'b1; m_phase <= PhGap;
          end else begin
            m_held <= m_held + 1;
          end
        end
        default: m_phase <= PhIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_grant", 32'(grant), 32'(m_grant));
      chk("model_id", 32'(grant_id), 32'(m_id));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_timeout", 32'(timeout), 32'(m_timeout));
    end
  end

  initial begin
    // Reset values
    step(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single requester: two-cycle latency, release, one gap cycle
    set_prio(0, 5);
    req = 4'b0001;
    step(1); chk("lat_n1", 32'(grant), 0);
    step(1); chk("lat_n2_grant", 32'(grant), 1);
    chk("lat_n2_id", 32'(grant_id), 0);
    chk("lat_n2_busy", 32'(busy), 1);
    step(2); req = '0;
    step(1); chk("rel_gap_grant", 32'(grant), 0);
    chk("rel_gap_busy", 32'(busy), 0);
    chk("rel_gap_id_hold", 32'(grant_id), 0);
    step(1);

    // Highest priority wins, then the other after GAP + ARB
    set_prio(1, 2); set_prio(3, 6);
    req = 4'b1010;
    step(2); chk("pri_grant", 32'(grant), 8);
    chk("pri_id", 32'(grant_id), 3);
    req = 4'b0010;
    step(1); chk("pri_gap", 32'(grant), 0);
    step(1); chk("pri_arb", 32'(grant), 0);
    step(1); chk("pri_second", 32'(grant), 2);
    chk("pri_second_id", 32'(grant_id), 1);
    req = '0;
    step(2);

    // Round-robin among equal priorities starting from pointer 0 after reset
    pulse_reset();
    for (int i = 0; i < N; i++) set_prio(i, 4);
    req = '1;
    step(2);
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      chk("rr_grant", 32'(grant), 32'(1 << e));
      chk("rr_id", 32'(grant_id), 32'(e));
      step(2); req[e] = 1'b0;
      step(1); chk("rr_gap", 32'(busy), 0);
      req[e] = 1'b1;
      step(2);
    end
    req = '0;
    step(2);

    // Hold timeout on requester 2, then requester 0 wins the tie
    req = 4'b0101;
    step(2); chk("to_first", 32'(grant), 4);
    for (int k = 0; k < 15; k++) begin
      step(1);
      chk("to_hold", 32'(grant), 4);
      chk("to_no_pulse", 32'(timeout), 0);
    end
    step(1); chk("to_revoke", 32'(grant), 0);
    chk("to_pulse", 32'(timeout), 1);
    step(1); chk("to_pulse_end", 32'(timeout), 0);
    chk("to_arb", 32'(grant), 0);
    step(1); chk("to_next", 32'(grant), 1);
    chk("to_next_id", 32'(grant_id), 0);

    // Asynchronous reset in the middle of a grant
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_timeout", 32'(timeout), 0);
    req = '0;
    step(1); rst_n = 1'b1;
    req = 4'b0100;
    step(1); chk("arst_lat1", 32'(grant), 0);
    step(1); chk("arst_lat2", 32'(grant), 4);
    req = '0;
    step(2);

    // Starvation: low priority requester 1 against repeated short grants to requester 0
    pulse_reset();
    set_prio(0, 7); set_prio(1, 1);
    req = 4'b0011;
    step(2);
    for (int r = 0; r < 5; r++) begin
      e = (AGING && r == 3) ? 1 : 0;
      chk("age_grant", 32'(grant), 32'(1 << e));
      step(1); req[e] = 1'b0;
      step(1); req[e] = 1'b1;
      step(2);
    end
    req = '0;
    step(2);

    // Randomized traffic against the reference model
    pulse_reset();
    req  = NREQ'($urandom);
    prio = (NREQ*PW)'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(15) == 0) prio = (NREQ*PW)'($urandom);
    end
    req = '0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_rr_sched.md
Name: prio_rr_sched

Overview:
- Sequential scheduler that shares one compare/select datapath resource among NREQ requesters.
- Each requester presents a request plus a PW-bit priority code.
- Block picks the highest-priority requester, breaks ties round-robin, and holds the grant until release or timeout.
- Sits in front of the shared select/compare logic and drives its one-hot select lines.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PW, 3, priority code width; larger value = higher priority.
- MAX_HOLD, 16, max cycles a grant may be held before forced revoke (>=2).
- IDW, 2, width of grant_id; must equal clog2(NREQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request level per requester; held high while owning.
- prio  in  NREQ*PW  priority codes; requester i uses bits [i*PW +: PW].
- grant  out  NREQ  one-hot grant, registered.
- grant_id  out  IDW  binary index of granted requester; valid when busy=1.
- busy  out  1  resource currently granted.
- timeout  out  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Reset (async assert, sync deassert usage): grant=0, grant_id=0, busy=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- FSM: IDLE -> ARB -> GRANT -> GAP -> IDLE/ARB.
- IDLE:
  - if |req, snapshot req and prio into registers, go to ARB; else stay.
- ARB (one cycle, uses snapshot only):
  - winner = requester with max prio among snapshotted requests.
  - Ties: first tied index at or after rr_ptr, scanning upward with wrap at NREQ-1 -> 0.
  - If the live req of the winner has dropped, discard the snapshot and go to IDLE (no grant).
  - Else set grant/grant_id/busy on the ARB->GRANT edge, hold_cnt=1, rr_ptr=winner+1 mod NREQ.
- Latency: req rising in cycle N (block IDLE) -> grant visible at cycle N+2.
- GRANT:
  - Each cycle: if req[grant_id]=0, clear grant/busy next edge and go to GAP.
  - Else if hold_cnt==MAX_HOLD, clear grant/busy, pulse timeout for exactly one cycle, go to GAP.
  - Else hold_cnt++ (counter width clog2(MAX_HOLD+1), never wraps).
  - Priority changes during GRANT are ignored; no preemption.
- GAP: one idle cycle (busy=0, grant=0), then:
  - ARB if |req (new snapshot taken that edge),
  - else IDLE.
- A timed-out requester still asserting req re-competes normally. Because rr_ptr already advanced, it loses ties to other equal-priority requesters.
- Simultaneous release and MAX_HOLD in the same cycle: treat as release, no timeout pulse.
- Reset mid-GRANT: grant drops immediately (async); rr_ptr returns to 0.
- grant is always one-hot or zero. busy == |grant. grant_id holds its last value while busy=0.
- All outputs registered; no combinational path from req/prio to outputs.

Optional Feature:
- Macro PRIO_RR_SCHED_AGING_EN.
- With the macro:
  - Each requester has a 2-bit saturating age counter.
  - In ARB it increments for every snapshotted requester that loses, and clears for the winner or when its req is low.
  - A requester with age==3 outranks any prio value. Ties among aged requesters use the round-robin rule.
  - Counters reset to 0.
- Without the macro: no age state; arbitration is purely prio plus round-robin.

Test Plan:
- Reset, then req=4'b0001, prio[0]=5 -> grant=0001 two cycles after req, grant_id=0, busy=1. Drop req -> grant=0 next edge, one GAP cycle.
- req=4'b1010, prio[1]=2, prio[3]=6 -> grant=1000, grant_id=3. Release -> GAP, then grant=0010.
- All four req high, all prio=4, each released after 3 cycles -> grant order 0,1,2,3,0, each separated by ARB+GAP.
- req[2] held high with MAX_HOLD=16 -> grant held exactly 16 cycles, timeout=1 for one cycle, grant=0. With req[0] also high at equal prio, requester 0 wins next.
- Assert rst_n=0 mid-GRANT -> grant/busy/timeout=0 in the same cycle. After release, req=4'b0100 -> grant after 2 cycles, rr_ptr starting from 0.
- PRIO_RR_SCHED_AGING_EN defined: req[0] prio=7 with repeated short grants, req[1] prio=1 continuous -> requester 1 granted after losing 3 arbitrations. Without the macro, requester 1 is never granted while req[0] re-requests.
